// File: rtl/pe_dsp_share_arb.sv
// pe_dsp_share_arb: shares one dual 18x18 unsigned multiplier DSP among NUM_REQ
// requesters. Round-robin grant with credit guard, registered operand drive,
// latency-matched tag pipeline and a response FIFO with a registered head.
// Optional statistics counters are built when PE_DSP_ARB_STATS_EN is defined.
module pe_dsp_share_arb #(
  parameter int NUM_REQ     = 4,
  parameter int DSP_LATENCY = 3,
  parameter int FIFO_DEPTH  = 8,
  parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*18-1:0]   req_ax,
  input  logic [NUM_REQ*18-1:0]   req_ay,
  input  logic [NUM_REQ*18-1:0]   req_bx,
  input  logic [NUM_REQ*18-1:0]   req_by,
  output logic [17:0]             dsp_ax,
  output logic [17:0]             dsp_ay,
  output logic [17:0]             dsp_bx,
  output logic [17:0]             dsp_by,
  input  logic [35:0]             dsp_resulta,
  input  logic [35:0]             dsp_resultb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [35:0]             rsp_resulta,
  output logic [35:0]             rsp_resultb
`ifdef PE_DSP_ARB_STATS_EN
  ,
  output logic [31:0]             stat_issue_cnt,
  output logic [31:0]             stat_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 2;
  localparam int ENT_W = ID_W + 72;

  // Per-requester operand views of the flattened buses
  logic [17:0] ax_arr [NUM_REQ];
  logic [17:0] ay_arr [NUM_REQ];
  logic [17:0] bx_arr [NUM_REQ];
  logic [17:0] by_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unflat
      assign ax_arr[gi] = req_ax[18*gi +: 18];
      assign ay_arr[gi] = req_ay[18*gi +: 18];
      assign bx_arr[gi] = req_bx[18*gi +: 18];
      assign by_arr[gi] = req_by[18*gi +: 18];
    end
  endgenerate

  logic [ID_W-1:0]  ptr_reg;
  logic [CNT_W-1:0] inflight_reg;
  logic [PTR_W:0]   mem_count_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic             out_valid_reg;
  logic [ENT_W-1:0] out_word_reg;
  logic [ENT_W-1:0] mem [FIFO_DEPTH];

  logic             tag_v_reg  [DSP_LATENCY+1];
  logic [ID_W-1:0]  tag_id_reg [DSP_LATENCY+1];

  logic [CNT_W-1:0] occ;
  logic             credit_ok;
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W:0]    cand;
  logic             issue;
  logic [ID_W-1:0]  ptr_next;
  logic             push;
  logic [ENT_W-1:0] push_word;
  logic             pop;
  logic             out_load;
  logic             from_mem;
  logic             bypass;
  logic             mem_wr;

  // Credit: everything already queued plus everything still inside the DSP
  always_comb begin
    occ       = CNT_W'(mem_count_reg) + CNT_W'(out_valid_reg);
    credit_ok = (occ + inflight_reg) < CNT_W'(FIFO_DEPTH);
  end

  // Round-robin search: first valid requester at or after the pointer
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_reg} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // One-hot grant, suppressed without credit and while reset is held
  always_comb begin
    issue     = grant_found && credit_ok && !reset;
    req_ready = '0;
    if (issue) begin
      req_ready[grant_idx] = 1'b1;
    end
    if (grant_idx == ID_W'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_idx + ID_W'(1);
    end
  end

  // Round-robin pointer advances past the requester just served
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (issue) begin
      ptr_reg <= ptr_next;
    end
  end

  // Operand register feeding the DSP; holds its value on idle cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      dsp_ax <= '0;
      dsp_ay <= '0;
      dsp_bx <= '0;
      dsp_by <= '0;
    end else if (issue) begin
      dsp_ax <= ax_arr[grant_idx];
      dsp_ay <= ay_arr[grant_idx];
      dsp_bx <= bx_arr[grant_idx];
      dsp_by <= by_arr[grant_idx];
    end
  end

  // Tag pipe: stage 0 lines up with the operand register, last stage with the product
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s <= DSP_LATENCY; s++) begin
        tag_v_reg[s]  <= 1'b0;
        tag_id_reg[s] <= '0;
      end
    end else begin
      tag_v_reg[0]  <= issue;
      tag_id_reg[0] <= grant_idx;
      for (int s = 1; s <= DSP_LATENCY; s++) begin
        tag_v_reg[s]  <= tag_v_reg[s-1];
        tag_id_reg[s] <= tag_id_reg[s-1];
      end
    end
  end

  // FIFO control: the head register refills from memory, or straight from the DSP when memory is empty
  always_comb begin
    push      = tag_v_reg[DSP_LATENCY];
    push_word = {tag_id_reg[DSP_LATENCY], dsp_resulta, dsp_resultb};
    pop       = out_valid_reg && rsp_ready;
    out_load  = !out_valid_reg || pop;
    from_mem  = out_load && (mem_count_reg != '0);
    bypass    = out_load && (mem_count_reg == '0) && push;
    mem_wr    = push && !bypass;
  end

  // Products issued but not yet written into the FIFO
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_reg <= '0;
    end else begin
      case ({issue, push})
        2'b10:   inflight_reg <= inflight_reg + CNT_W'(1);
        2'b01:   inflight_reg <= inflight_reg - CNT_W'(1);
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  // FIFO storage array (no reset so it can map to block RAM)
  always_ff @(posedge clock) begin
    if (mem_wr) begin
      mem[wr_ptr_reg] <= push_word;
    end
  end

  // FIFO pointers and count
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      mem_count_reg <= '0;
    end else begin
      if (mem_wr) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (from_mem) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({mem_wr, from_mem})
        2'b10:   mem_count_reg <= mem_count_reg + (PTR_W+1)'(1);
        2'b01:   mem_count_reg <= mem_count_reg - (PTR_W+1)'(1);
        default: mem_count_reg <= mem_count_reg;
      endcase
    end
  end

  // Registered response head; held while the consumer stalls
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_word_reg  <= '0;
    end else if (out_load) begin
      if (from_mem) begin
        out_valid_reg <= 1'b1;
        out_word_reg  <= mem[rd_ptr_reg];
      end else if (push) begin
        out_valid_reg <= 1'b1;
        out_word_reg  <= push_word;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  // Credit accounting must never let a product arrive at a full FIFO
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      assert (occ < CNT_W'(FIFO_DEPTH));
    end
  end

  assign rsp_valid   = out_valid_reg;
  assign rsp_id      = out_word_reg[ENT_W-1 -: ID_W];
  assign rsp_resulta = out_word_reg[71:36];
  assign rsp_resultb = out_word_reg[35:0];

`ifdef PE_DSP_ARB_STATS_EN
  logic stall;
  assign stall = (|req_valid) && !credit_ok;

  // Saturating handshake and credit-stall counters
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_issue_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (issue && (stat_issue_cnt != 32'hFFFF_FFFF)) begin
        stat_issue_cnt <= stat_issue_cnt + 32'd1;
      end
      if (stall && (stat_stall_cnt != 32'hFFFF_FFFF)) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
